// File: rtl/coin_event_scheduler.sv
// Buffers coin/stop ticks in saturating counters and replays them as spaced, one-hot event pulses.
// Optional statistics outputs (issued_count, drop_count) are built when COIN_SCHED_STATS_EN is defined.
module coin_event_scheduler #(
   parameter int CNT_W = 3,
   parameter int GAP   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_1,
   input  logic        tick_5,
   input  logic        tick_10,
   input  logic        tick_stop,
   output logic        ev_1,
   output logic        ev_5,
   output logic        ev_10,
   output logic        ev_stop,
   output logic        pending,
   output logic        overflow
`ifdef COIN_SCHED_STATS_EN
   ,
   output logic [15:0] issued_count,
   output logic [7:0]  drop_count
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [1:0] SRC_1  = 2'd0;
   localparam logic [1:0] SRC_5  = 2'd1;
   localparam logic [1:0] SRC_10 = 2'd2;

   localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_r, state_s;
   logic [GAP_W-1:0] gap_r, gap_s;
   logic [1:0]       last_r, last_s;
   logic [CNT_W-1:0] cnt1_r, cnt5_r, cnt10_r;
   logic [CNT_W-1:0] cnt1_s, cnt5_s, cnt10_s;
   logic             stop_pend_r, stop_pend_s;
   logic             drop1_s, drop5_s, drop10_s;
   logic             g1_s, g5_s, g10_s, gstop_s;
   logic [2:0]       nz_s;
   logic [1:0]       pick_s;
   logic             busy_now_s, busy_next_s;

   // Next source after last, skipping empty counters; only called when some counter is nonzero.
   function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] nz);
      logic [1:0] sel;
      case (last)
         SRC_1: begin
            if (nz[1])      sel = SRC_5;
            else if (nz[2]) sel = SRC_10;
            else            sel = SRC_1;
         end
         SRC_5: begin
            if (nz[2])      sel = SRC_10;
            else if (nz[0]) sel = SRC_1;
            else            sel = SRC_5;
         end
         default: begin
            if (nz[0])      sel = SRC_1;
            else if (nz[1]) sel = SRC_5;
            else            sel = SRC_10;
         end
      endcase
      return sel;
   endfunction

   // Returns {dropped, next_count}; a grant frees a slot for a same-cycle tick.
   function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                               input logic tick, input logic grant);
      logic [CNT_W:0] res;
      if (tick && !grant) begin
         if (cnt == CNT_MAX) res = {1'b1, cnt};
         else                res = {1'b0, cnt + CNT_W'(1)};
      end else if (grant && !tick) begin
         res = {1'b0, cnt - CNT_W'(1)};
      end else begin
         res = {1'b0, cnt};
      end
      return res;
   endfunction

   assign nz_s   = {(cnt10_r != '0), (cnt5_r != '0), (cnt1_r != '0)};
   assign pick_s = rr_pick(last_r, nz_s);

   // FSM next state, grant selection and gap timing
   always_comb begin
      state_s = state_r;
      gap_s   = gap_r;
      last_s  = last_r;
      g1_s    = 1'b0;
      g5_s    = 1'b0;
      g10_s   = 1'b0;
      gstop_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (nz_s != 3'b000) begin
               last_s  = pick_s;
               state_s = ISSUE;
               case (pick_s)
                  SRC_1:   g1_s  = 1'b1;
                  SRC_5:   g5_s  = 1'b1;
                  default: g10_s = 1'b1;
               endcase
            end else if (stop_pend_r) begin
               gstop_s = 1'b1;
               state_s = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (GAP > 0) begin
               state_s = WAIT;
               gap_s   = '0;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (gap_r == GAP_LAST) begin
               state_s = IDLE;
            end else begin
               gap_s = gap_r + GAP_W'(1);
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Counter and stop-flag updates
   always_comb begin
      {drop1_s,  cnt1_s}  = cnt_step(cnt1_r,  tick_1,  g1_s);
      {drop5_s,  cnt5_s}  = cnt_step(cnt5_r,  tick_5,  g5_s);
      {drop10_s, cnt10_s} = cnt_step(cnt10_r, tick_10, g10_s);
      stop_pend_s = (stop_pend_r && !gstop_s) || tick_stop;
   end

   // pending stays up through the cycle in which the last grant is taken
   assign busy_now_s  = (nz_s != 3'b000) || stop_pend_r;
   assign busy_next_s = (cnt1_s != '0) || (cnt5_s != '0) || (cnt10_s != '0) || stop_pend_s;

   // State, buffers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         gap_r       <= '0;
         last_r      <= SRC_10;
         cnt1_r      <= '0;
         cnt5_r      <= '0;
         cnt10_r     <= '0;
         stop_pend_r <= 1'b0;
         ev_1        <= 1'b0;
         ev_5        <= 1'b0;
         ev_10       <= 1'b0;
         ev_stop     <= 1'b0;
         pending     <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state_r     <= state_s;
         gap_r       <= gap_s;
         last_r      <= last_s;
         cnt1_r      <= cnt1_s;
         cnt5_r      <= cnt5_s;
         cnt10_r     <= cnt10_s;
         stop_pend_r <= stop_pend_s;
         ev_1        <= g1_s;
         ev_5        <= g5_s;
         ev_10       <= g10_s;
         ev_stop     <= gstop_s;
         pending     <= busy_now_s || busy_next_s;
         overflow    <= overflow || drop1_s || drop5_s || drop10_s;
      end
   end

`ifdef COIN_SCHED_STATS_EN
   logic [1:0] ndrop_s;
   logic [8:0] drop_sum_s;

   assign ndrop_s    = {1'b0, drop1_s} + {1'b0, drop5_s} + {1'b0, drop10_s};
   assign drop_sum_s = {1'b0, drop_count} + {7'd0, ndrop_s};

   // Issue counter wraps; drop counter saturates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued_count <= 16'd0;
         drop_count   <= 8'd0;
      end else begin
         if (state_r == ISSUE) issued_count <= issued_count + 16'd1;
         drop_count <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
      end
   end
`endif

endmodule
